// File: rtl/fast_msg_pkg.sv
// Shared widths, tagged-beat layout and FSM states for FAST message dispatch/reassembly.
package fast_msg_pkg;

  localparam int unsigned BEAT_W  = 64;
  localparam int unsigned MAX_MSG = 10;
  localparam int unsigned NUM_ENC = 4;
  localparam int unsigned ID_W    = 21;

  localparam int unsigned IDX_W = $clog2(MAX_MSG);
  localparam int unsigned LEN_W = $clog2(MAX_MSG + 1);
  localparam int unsigned PTR_W = IDX_W + 1;
  localparam int unsigned TAG_W = 1 + ID_W + IDX_W + BEAT_W;

  typedef struct packed {
    logic              valid;
    logic [ID_W-1:0]   id;
    logic [IDX_W-1:0]  idx;
    logic [BEAT_W-1:0] data;
  } field_tag_t;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } dispatch_state_t;

endpackage

// File: rtl/fast_message_dispatch.sv
// Captures one FAST message and issues its fields as tagged beats, up to NUM_ENC per cycle,
// in field order, with all-or-nothing group issue across the encoder lanes.
module fast_message_dispatch
  import fast_msg_pkg::*;
(
  input  logic               clk,
  input  logic               rstn,
  input  logic               msg_valid,
  output logic               msg_ready,
  input  logic [ID_W-1:0]    msg_id,
  input  logic [LEN_W-1:0]   msg_len,
  input  logic [BEAT_W-1:0]  msg_fields [0:MAX_MSG-1],
  input  logic [NUM_ENC-1:0] lane_ready,
  output field_tag_t         lane_fields [0:NUM_ENC-1],
  output logic               msg_done,
  output logic               len_err,
  output logic               busy
);

  dispatch_state_t   state_q, state_d;
  logic [PTR_W-1:0]  ptr_q;
  logic [ID_W-1:0]   id_q;
  logic [LEN_W-1:0]  len_q;
  logic [BEAT_W-1:0] fields_q [0:MAX_MSG-1];

  logic [PTR_W-1:0]  remaining;
  logic [PTR_W-1:0]  grp;
  logic              grp_ok;
  logic              issue;
  logic              last;
  logic              capture;
  logic              len_bad;

  // Group sizing, issue decision, handshake and next state
  always_comb begin
    remaining = PTR_W'(len_q) - ptr_q;
    grp       = (remaining > PTR_W'(NUM_ENC)) ? PTR_W'(NUM_ENC) : remaining;
    grp_ok    = 1'b1;
    for (int j = 0; j < int'(NUM_ENC); j++) begin
      if ((PTR_W'(j) < grp) && !lane_ready[j]) grp_ok = 1'b0;
    end
    issue     = (state_q == SEND) && grp_ok;
    last      = issue && ((ptr_q + grp) == PTR_W'(len_q));
    // Ready during the final issue cycle lets the next message follow with no bubble
    msg_ready = (state_q == IDLE) || last;
    capture   = msg_valid && msg_ready;
    len_bad   = (msg_len == '0) || (msg_len > LEN_W'(MAX_MSG));
    state_d   = state_q;
    if (state_q == IDLE) begin
      if (capture && !len_bad) state_d = SEND;
    end else begin
      if (last) state_d = (capture && !len_bad) ? SEND : IDLE;
    end
  end

  // Control state, pulses and registered lane beats
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      msg_done <= 1'b0;
      len_err  <= 1'b0;
      for (int j = 0; j < int'(NUM_ENC); j++) lane_fields[j] <= '0;
    end else begin
      state_q  <= state_d;
      msg_done <= last;
      len_err  <= capture && len_bad;
      if (capture)    ptr_q <= '0;
      else if (issue) ptr_q <= ptr_q + grp;
      for (int j = 0; j < int'(NUM_ENC); j++) begin
        if (issue && (PTR_W'(j) < grp)) begin
          lane_fields[j] <= {1'b1, id_q, IDX_W'(ptr_q + PTR_W'(j)),
                             fields_q[IDX_W'(ptr_q + PTR_W'(j))]};
        end else begin
          lane_fields[j] <= '0;
        end
      end
    end
  end

  // Message holding registers; contents only matter while in SEND
  always_ff @(posedge clk) begin
    if (capture) begin
      id_q     <= msg_id;
      len_q    <= msg_len;
      fields_q <= msg_fields;
    end
  end

  assign busy = (state_q == SEND);

endmodule

// File: tb/tb_fast_message_dispatch.sv
// Directed bench for fast_message_dispatch: group issue, stalls, back-to-back, length errors, reset.
module tb_fast_message_dispatch;
  import fast_msg_pkg::*;

  logic               clk = 1'b0;
  logic               rstn;
  logic               msg_valid;
  logic               msg_ready;
  logic [ID_W-1:0]    msg_id;
  logic [LEN_W-1:0]   msg_len;
  logic [BEAT_W-1:0]  msg_fields [0:MAX_MSG-1];
  logic [NUM_ENC-1:0] lane_ready;
  field_tag_t         lane_fields [0:NUM_ENC-1];
  logic               msg_done;
  logic               len_err;
  logic               busy;

  int n_vec = 0;
  int n_err = 0;

  fast_message_dispatch dut (
    .clk         (clk),
    .rstn        (rstn),
    .msg_valid   (msg_valid),
    .msg_ready   (msg_ready),
    .msg_id      (msg_id),
    .msg_len     (msg_len),
    .msg_fields  (msg_fields),
    .lane_ready  (lane_ready),
    .lane_fields (lane_fields),
    .msg_done    (msg_done),
    .len_err     (len_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic offer(input logic [31:0] id, input logic [31:0] len, input logic [63:0] base);
    msg_id    = ID_W'(id);
    msg_len   = LEN_W'(len);
    for (int i = 0; i < int'(MAX_MSG); i++) msg_fields[i] = base + 64'(i);
    msg_valid = 1'b1;
  endtask

  // Overwrite the inputs so any read past capture shows up as wrong data
  task automatic scramble();
    msg_valid = 1'b0;
    msg_id    = '1;
    msg_len   = '0;
    for (int i = 0; i < int'(MAX_MSG); i++) msg_fields[i] = 64'hDEAD_0000 + 64'(i);
  endtask

  task automatic exp_lanes(input string tag, input logic [31:0] id, input int first, input int n,
                           input logic [63:0] base, input logic done);
    for (int j = 0; j < int'(NUM_ENC); j++) begin
      if (j < n)
        chk($sformatf("%s.lane%0d", tag, j), 128'(lane_fields[j]),
            128'({1'b1, ID_W'(id), IDX_W'(first + j), BEAT_W'(base + 64'(first + j))}));
      else
        chk($sformatf("%s.lane%0d.valid", tag, j), 128'(lane_fields[j].valid), 128'(0));
    end
    chk({tag, ".done"}, 128'(msg_done), 128'(done));
  endtask

  initial begin
    rstn       = 1'b0;
    lane_ready = 4'hF;
    scramble();
    repeat (2) tick();
    exp_lanes("rst", 0, 0, 0, 0, 1'b0);
    chk("rst.busy", 128'(busy), 128'(0));
    chk("rst.len_err", 128'(len_err), 128'(0));
    chk("rst.ready", 128'(msg_ready), 128'(1));
    rstn = 1'b1;
    tick();

    // len=10, all lanes ready: groups {0-3},{4-7},{8,9}
    offer(32'h1A, 10, 64'h100);
    chk("t1.ready_idle", 128'(msg_ready), 128'(1));
    tick(); scramble();
    exp_lanes("t1.c0", 0, 0, 0, 0, 1'b0);
    chk("t1.busy", 128'(busy), 128'(1));
    chk("t1.ready_send", 128'(msg_ready), 128'(0));
    tick();
    exp_lanes("t1.g0", 32'h1A, 0, 4, 64'h100, 1'b0);
    chk("t1.ready_g0", 128'(msg_ready), 128'(0));
    tick();
    exp_lanes("t1.g1", 32'h1A, 4, 4, 64'h100, 1'b0);
    chk("t1.ready_last_issue", 128'(msg_ready), 128'(1));
    tick();
    exp_lanes("t1.g2", 32'h1A, 8, 2, 64'h100, 1'b1);
    chk("t1.ready_g2", 128'(msg_ready), 128'(1));
    chk("t1.busy_end", 128'(busy), 128'(0));

    // Same message, lane 2 stalled for three issue opportunities
    offer(32'h1A, 10, 64'h100);
    lane_ready = 4'b1011;
    tick(); scramble();
    exp_lanes("t2.s0", 0, 0, 0, 0, 1'b0);
    chk("t2.busy", 128'(busy), 128'(1));
    tick();
    exp_lanes("t2.s1", 0, 0, 0, 0, 1'b0);
    chk("t2.ready_stall", 128'(msg_ready), 128'(0));
    tick();
    exp_lanes("t2.s2", 0, 0, 0, 0, 1'b0);
    tick();
    exp_lanes("t2.s3", 0, 0, 0, 0, 1'b0);
    lane_ready = 4'hF;
    tick();
    exp_lanes("t2.g0", 32'h1A, 0, 4, 64'h100, 1'b0);
    tick();
    exp_lanes("t2.g1", 32'h1A, 4, 4, 64'h100, 1'b0);
    tick();
    exp_lanes("t2.g2", 32'h1A, 8, 2, 64'h100, 1'b1);

    // Back-to-back: id5 len4 then id6 len2 with no bubble
    offer(32'h5, 4, 64'h500);
    chk("t3.ready0", 128'(msg_ready), 128'(1));
    tick();
    offer(32'h6, 2, 64'h600);
    chk("t3.ready_last", 128'(msg_ready), 128'(1));
    exp_lanes("t3.c0", 0, 0, 0, 0, 1'b0);
    tick();
    exp_lanes("t3.id5", 32'h5, 0, 4, 64'h500, 1'b1);
    chk("t3.busy_id6", 128'(busy), 128'(1));
    chk("t3.ready_id6", 128'(msg_ready), 128'(1));
    scramble();
    tick();
    exp_lanes("t3.id6", 32'h6, 0, 2, 64'h600, 1'b1);
    chk("t3.busy_end", 128'(busy), 128'(0));
    tick();
    exp_lanes("t3.idle", 0, 0, 0, 0, 1'b0);

    // Illegal lengths 0 and 11, then a legal len=3 message
    offer(32'h7, 0, 64'h700);
    tick();
    chk("t4.err0", 128'(len_err), 128'(1));
    chk("t4.busy0", 128'(busy), 128'(0));
    exp_lanes("t4.e0", 0, 0, 0, 0, 1'b0);
    msg_len = LEN_W'(11);
    tick();
    chk("t4.err11", 128'(len_err), 128'(1));
    chk("t4.busy11", 128'(busy), 128'(0));
    exp_lanes("t4.e11", 0, 0, 0, 0, 1'b0);
    scramble();
    tick();
    chk("t4.err_clr", 128'(len_err), 128'(0));
    chk("t4.busy_clr", 128'(busy), 128'(0));
    exp_lanes("t4.e_clr", 0, 0, 0, 0, 1'b0);
    offer(32'h8, 3, 64'h800);
    tick(); scramble();
    exp_lanes("t4.c0", 0, 0, 0, 0, 1'b0);
    tick();
    exp_lanes("t4.g0", 32'h8, 0, 3, 64'h800, 1'b1);
    chk("t4.err_legal", 128'(len_err), 128'(0));

    // Reset after the first group discards the rest of the message
    offer(32'h33, 10, 64'h300);
    tick(); scramble();
    tick();
    exp_lanes("t5.g0", 32'h33, 0, 4, 64'h300, 1'b0);
    rstn = 1'b0;
    tick();
    exp_lanes("t5.rst", 0, 0, 0, 0, 1'b0);
    chk("t5.busy_rst", 128'(busy), 128'(0));
    chk("t5.ready_rst", 128'(msg_ready), 128'(1));
    rstn = 1'b1;
    tick();
    exp_lanes("t5.after1", 0, 0, 0, 0, 1'b0);
    chk("t5.busy_after", 128'(busy), 128'(0));
    tick();
    exp_lanes("t5.after2", 0, 0, 0, 0, 1'b0);

    // len=1 with only lane 0 ready
    offer(32'h1F, 1, 64'h700);
    lane_ready = 4'b0001;
    tick(); scramble();
    exp_lanes("t6.c0", 0, 0, 0, 0, 1'b0);
    tick();
    exp_lanes("t6.g0", 32'h1F, 0, 1, 64'h700, 1'b1);
    tick();
    exp_lanes("t6.idle", 0, 0, 0, 0, 1'b0);
    chk("t6.busy", 128'(busy), 128'(0));
    lane_ready = 4'hF;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
